// File: rtl/input_buffer.sv
// Receive-side stream buffer: registered in_ready, circular store with a combinational head read.
// Optional stall counter output (stall_cycles) is enabled with `define INPUT_BUFFER_STATS_EN.
module input_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  count
`ifdef INPUT_BUFFER_STATS_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  // Handshake: a beat moves on a rising aclk edge where valid and ready are both high.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  in_ready_q, in_ready_d;
  logic                  push, pop;

  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign in_ready  = in_ready_q;
  assign count     = count_q;

  always_comb begin
    push       = in_valid & in_ready_q;
    pop        = out_valid & out_ready;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
    // Ready looks at post-edge occupancy so a full buffer can never be overrun.
    in_ready_d = (count_d < CNT_WIDTH'(DEPTH));
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

`ifdef INPUT_BUFFER_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      stall_q <= '0;
    end else if (in_valid && !in_ready_q && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_input_buffer.sv
// Directed and random checks for input_buffer (DEPTH=4, DATA_WIDTH=32).
module tb_input_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          aclk;
  logic          areset;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;
`ifdef INPUT_BUFFER_STATS_EN
  logic [31:0]   stall_cycles;
`endif

  input_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .aclk      (aclk),
    .areset    (areset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
`ifdef INPUT_BUFFER_STATS_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  // ---------------- clock / reset ----------------
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic          m_ready;
  int unsigned   stall_exp;
  int            n_checks;
  int            n_errors;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(m_ready));
    chk({tag, ".count"}, 64'(count), 64'(exp_q.size()));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk({tag, ".out_data"}, 64'(out_data), 64'(exp_q[0]));
  endtask

  task automatic chk_stats();
`ifdef INPUT_BUFFER_STATS_EN
    chk("stall_cycles", 64'(stall_cycles), 64'(stall_exp));
`endif
  endtask

  // ---------------- driver tasks ----------------
  // One clock edge; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    logic push_m, pop_m;
    push_m = in_valid && m_ready;
    pop_m  = (exp_q.size() != 0) && out_ready;
    if (in_valid && !m_ready) stall_exp++;
    @(posedge aclk);
    if (pop_m)  void'(exp_q.pop_front());
    if (push_m) exp_q.push_back(in_data);
    m_ready = (exp_q.size() < DEPTH);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [DW-1:0] d, input logic ordy);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
  endtask

  task automatic apply_reset();
    areset = 1'b1;
    #1;
    chk("rst.in_ready", 64'(in_ready), 64'd0);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.count", 64'(count), 64'd0);
    drive(1'b0, '0, 1'b0);
    @(posedge aclk);
    @(posedge aclk);
    #1;
    chk("rst_held.in_ready", 64'(in_ready), 64'd0);
    areset = 1'b0;
    exp_q.delete();
    m_ready   = 1'b0;
    stall_exp = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          e_ov;
    logic [DW-1:0] e_dat;
    logic          e_ir;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int sent, rcvd, cyc;
    n_checks  = 0;
    n_errors  = 0;
    stall_exp = 0;
    m_ready   = 1'b0;
    areset    = 1'b0;
    drive(1'b0, '0, 1'b0);

    // fill to full, pop once, then mixed push/pop and drain through empty
    vecs[0]  = '{1'b1, 32'h1, 1'b0, 1'b1, 32'h1, 1'b1, 3'd1};
    vecs[1]  = '{1'b1, 32'h2, 1'b0, 1'b1, 32'h1, 1'b1, 3'd2};
    vecs[2]  = '{1'b1, 32'h3, 1'b0, 1'b1, 32'h1, 1'b1, 3'd3};
    vecs[3]  = '{1'b1, 32'h4, 1'b0, 1'b1, 32'h1, 1'b0, 3'd4};
    vecs[4]  = '{1'b1, 32'h5, 1'b1, 1'b1, 32'h2, 1'b1, 3'd3};
    vecs[5]  = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h2, 1'b1, 3'd3};
    vecs[6]  = '{1'b1, 32'h6, 1'b1, 1'b1, 32'h3, 1'b1, 3'd3};
    vecs[7]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 1'b1, 3'd2};
    vecs[8]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h6, 1'b1, 3'd1};
    vecs[9]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 3'd0};
    vecs[10] = '{1'b1, 32'h7, 1'b1, 1'b1, 32'h7, 1'b1, 3'd1};
    vecs[11] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 3'd0};

    // reset then idle, asserted mid-cycle
    #3;
    apply_reset();
    step();
    chk("idle1.in_ready", 64'(in_ready), 64'd1);
    step();
    chk("idle2.in_ready", 64'(in_ready), 64'd1);
    chk("idle2.out_valid", 64'(out_valid), 64'd0);
    chk("idle2.count", 64'(count), 64'd0);

    // single beat held for 5 idle cycles
    drive(1'b1, 32'hDEAD_BEEF, 1'b0);
    step();
    drive(1'b0, '0, 1'b0);
    chk("single.out_valid", 64'(out_valid), 64'd1);
    chk("single.out_data", 64'(out_data), 64'hDEAD_BEEF);
    chk("single.count", 64'(count), 64'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("single_hold.out_data", 64'(out_data), 64'hDEAD_BEEF);
      chk("single_hold.out_valid", 64'(out_valid), 64'd1);
    end
    chk_stats();

    // table-driven fill/drain
    apply_reset();
    step();
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].iv, vecs[i].d, vecs[i].ordy);
      step();
      chk($sformatf("vec%0d.out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
      if (vecs[i].e_ov) chk($sformatf("vec%0d.out_data", i), 64'(out_data), 64'(vecs[i].e_dat));
      chk($sformatf("vec%0d.in_ready", i), 64'(in_ready), 64'(vecs[i].e_ir));
      chk($sformatf("vec%0d.count", i), 64'(count), 64'(vecs[i].e_cnt));
    end
    drive(1'b0, '0, 1'b0);

    // streaming 0..99 with pointer wrap and no bubbles
    for (int k = 0; k < 100; k++) begin
      drive(1'b1, DW'(k), 1'b1);
      step();
      chk("stream.out_valid", 64'(out_valid), 64'd1);
      chk("stream.count", 64'(count), 64'd1);
      chk("stream.out_data", 64'(out_data), 64'(k));
    end
    drive(1'b0, '0, 1'b1);
    step();
    chk("stream_drain.count", 64'(count), 64'd0);
    drive(1'b0, '0, 1'b0);

    // random valid/backpressure, 1000 beats
    sent = 0;
    rcvd = 0;
    cyc  = 0;
    while (rcvd < 1000 && cyc < 20000) begin
      logic push_m, pop_m;
      drive((sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0, $urandom, 1'($urandom_range(0, 1)));
      push_m = in_valid && m_ready;
      pop_m  = (exp_q.size() != 0) && out_ready;
      step();
      if (push_m) sent++;
      if (pop_m)  rcvd++;
      cyc++;
      chk_model("rand");
      chk("rand.full_no_ready", 64'(in_ready && (count == CW'(DEPTH))), 64'd0);
    end
    chk("rand.beats_received", 64'(rcvd), 64'd1000);
    drive(1'b0, '0, 1'b0);
    chk_stats();

    // reset mid-stream with three beats buffered
    drive(1'b1, 32'h11, 1'b0);
    step();
    drive(1'b1, 32'h22, 1'b0);
    step();
    drive(1'b1, 32'h33, 1'b0);
    step();
    drive(1'b0, '0, 1'b0);
    chk("pre_rst.count", 64'(count), 64'd3);
    #2;
    apply_reset();
    step();
    chk("post_rst.in_ready", 64'(in_ready), 64'd1);
    chk("post_rst.out_valid", 64'(out_valid), 64'd0);
    drive(1'b1, 32'hA5, 1'b0);
    step();
    drive(1'b0, '0, 1'b0);
    chk("post_rst.out_data", 64'(out_data), 64'hA5);
    chk("post_rst.count", 64'(count), 64'd1);
    drive(1'b0, '0, 1'b1);
    step();
    chk("post_rst_drain.count", 64'(count), 64'd0);
    chk("post_rst_drain.out_valid", 64'(out_valid), 64'd0);
    chk_stats();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
